// File: rtl/ahb_wait_slave_if.sv
// AHB bus bundle between a master (or bench) and the ahb_wait_slave responder.
interface ahb_wait_slave_if #(
   parameter int unsigned HAMAX = 32,
   parameter int unsigned HDMAX = 32
);
   logic             hsel;
   logic             hready_ba;
   logic             hwrite;
   logic [HAMAX-1:0] haddr;
   logic [1:0]       htrans;
   logic [2:0]       hsize;
   logic [HDMAX-1:0] hwdata;
   logic             hready_resp;
   logic [1:0]       hresp;
   logic [HDMAX-1:0] hrdata;

   modport master (
      output hsel,
      output hready_ba,
      output hwrite,
      output haddr,
      output htrans,
      output hsize,
      output hwdata,
      input  hready_resp,
      input  hresp,
      input  hrdata
   );

   modport slave (
      input  hsel,
      input  hready_ba,
      input  hwrite,
      input  haddr,
      input  htrans,
      input  hsize,
      input  hwdata,
      output hready_resp,
      output hresp,
      output hrdata
   );
endinterface

// File: rtl/ahb_wait_slave.sv
// AHB slave with a word-addressed register file and a fixed number of wait states per
// legal transfer. Illegal transfers (misaligned, non-word, out of range) get a two-cycle
// ERROR response and never touch memory.
module ahb_wait_slave #(
   parameter int unsigned HAMAX      = 32,
   parameter int unsigned HDMAX      = 32,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned WAITS      = 2
) (
   input logic hclk,
   input logic hresetn,
   ahb_wait_slave_if.slave bus
);

   localparam int unsigned Depth    = 2 ** DEPTH_LOG2;
   localparam bit          HasWaits = (WAITS > 0);
   localparam logic [3:0]  CntInit  = HasWaits ? 4'(WAITS - 1) : 4'd0;
   localparam logic [1:0]  RespOkay = 2'b00;
   localparam logic [1:0]  RespErr  = 2'b01;

   typedef enum logic [2:0] {
      StIdle,
      StWait,
      StData,
      StErr1,
      StErr2
   } state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [3:0]            r_cnt;
   logic [3:0]            w_cnt_d;
   logic                  r_write;
   logic [DEPTH_LOG2-1:0] r_index;
   logic [HDMAX-1:0]      r_mem [Depth];
   logic [HDMAX-1:0]      r_hrdata;

   logic                  w_can_accept;
   logic                  w_accept;
   logic                  w_illegal;
   logic [DEPTH_LOG2-1:0] w_addr_index;
   logic                  w_ready;
   logic [1:0]            w_resp;
   logic                  w_next_write;
   logic [DEPTH_LOG2-1:0] w_next_index;
   logic                  w_rd_load;
   logic                  w_fwd;
   logic [HDMAX-1:0]      w_rd_value;

   // Address-phase decode: accept only NONSEQ/SEQ while this slave can take a new transfer.
   always_comb begin
      w_addr_index = bus.haddr[DEPTH_LOG2+1:2];
      w_can_accept = (r_state == StIdle) || (r_state == StData) || (r_state == StErr2);
      w_accept     = bus.hsel && bus.hready_ba && w_can_accept &&
                     ((bus.htrans == 2'b10) || (bus.htrans == 2'b11));
      w_illegal    = (bus.haddr[1:0] != 2'b00) || (bus.hsize != 3'b010) ||
                     (|bus.haddr[HAMAX-1:DEPTH_LOG2+2]);
   end

   // Next-state, wait counter and response outputs.
   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_ready   = 1'b1;
      w_resp    = RespOkay;
      unique case (r_state)
         StIdle, StData, StErr2: begin
            if (r_state == StErr2) begin
               w_resp = RespErr;
            end
            w_state_d = StIdle;
            if (w_accept) begin
               if (w_illegal) begin
                  w_state_d = StErr1;
               end else if (HasWaits) begin
                  w_state_d = StWait;
                  w_cnt_d   = CntInit;
               end else begin
                  w_state_d = StData;
               end
            end
         end
         StWait: begin
            w_ready = 1'b0;
            if (r_cnt == 4'd0) begin
               w_state_d = StData;
            end else begin
               w_cnt_d = r_cnt - 4'd1;
            end
         end
         StErr1: begin
            w_ready   = 1'b0;
            w_resp    = RespErr;
            w_state_d = StErr2;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Read data is captured on entry to DATA. With zero wait states a read can enter DATA
   // straight from a write's DATA cycle, so the in-flight write data is forwarded.
   always_comb begin
      if (r_state == StWait) begin
         w_next_write = r_write;
         w_next_index = r_index;
      end else begin
         w_next_write = bus.hwrite;
         w_next_index = w_addr_index;
      end
      w_rd_load  = (w_state_d == StData) && !w_next_write;
      w_fwd      = (r_state == StData) && r_write && (r_index == w_next_index);
      w_rd_value = w_fwd ? bus.hwdata : r_mem[w_next_index];
   end

   // State, counter and latched transfer attributes.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         r_state <= StIdle;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_index <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_accept) begin
            r_write <= bus.hwrite;
            r_index <= w_addr_index;
         end
      end
   end

   // Register file: writes commit at the end of the DATA cycle; reset clears every word.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         for (int i = 0; i < Depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if ((r_state == StData) && r_write) begin
         r_mem[r_index] <= bus.hwdata;
      end
   end

   // Read data register; holds its value outside read DATA cycles.
   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         r_hrdata <= '0;
      end else if (w_rd_load) begin
         r_hrdata <= w_rd_value;
      end
   end

   assign bus.hready_resp = w_ready;
   assign bus.hresp       = w_resp;
   assign bus.hrdata      = r_hrdata;

endmodule
